// File: rtl/bringup_pkg.sv
// Shared types and constants for the bringup reporter.
// Event byte layout: bit7 = sensed value, bits6:0 = sensor index.
package bringup_pkg;

    localparam int          IDX_BITS       = 7;
    localparam int          MAX_SENSORS    = 127;
    localparam logic [7:0]  HEARTBEAT_BYTE = 8'hFF;
    localparam int          VALUE_BIT      = 7;
    localparam int          IDX_MSB        = 6;

    typedef enum logic {
        SCAN,
        EMIT
    } state_t;

    function automatic logic [7:0] event_byte(
        input logic                value,
        input logic [IDX_BITS-1:0] idx
    );
        logic [7:0] b;
        b                = 8'h00;
        b[VALUE_BIT]     = value;
        b[IDX_MSB:0]     = idx;
        return b;
    endfunction

endpackage

// File: rtl/bringup_reporter_if.sv
// Valid/ready event byte stream between the reporter and its consumer.
// master drives data_o/valid_o, slave drives ready_i.
interface bringup_reporter_if;

    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;

    modport master (
        output data_o,
        output valid_o,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  valid_o,
        output ready_i
    );

endinterface

// File: rtl/bringup_tick.sv
// Free-running divider: tick_o is high one cycle in every PERIOD.
// The first tick lands in cycle PERIOD-1 after reset release.
module bringup_tick #(
    parameter int PERIOD = 1024
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick_o
);

    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt_q;

    // Count 0..PERIOD-1 and wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/bringup_reporter.sv
// Scans sensor outputs and streams one byte per change; drives dec_o.
// Optional heartbeat byte when BRINGUP_REPORTER_HEARTBEAT_EN is defined.
module bringup_reporter
    import bringup_pkg::*;
#(
    parameter int NUM_SENSORS      = 32,
    parameter int DEC_PERIOD       = 1024,
    parameter int HEARTBEAT_PERIOD = 1 << 20
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_SENSORS-1:0] sensed_i,
    output logic                   dec_o,
    output logic                   busy_o,
    bringup_reporter_if.master     evt
);

    if (NUM_SENSORS < 1 || NUM_SENSORS > MAX_SENSORS ||
        DEC_PERIOD < 2 || HEARTBEAT_PERIOD < 2) begin : g_bad_param
        $error("bringup_reporter: illegal parameter value");
    end

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_SENSORS - 1);

    state_t                state_q, state_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d, idx_next;
    logic [7:0]            data_q, data_d;
    logic [MAX_SENSORS:0]  rep_q, rep_d;
    logic [MAX_SENSORS:0]  sensed_ext;
    logic                  cur;
    logic                  hb_pend;

    bringup_tick #(.PERIOD(DEC_PERIOD)) u_dec (
        .clock   (clock),
        .reset_n (reset_n),
        .tick_o  (dec_o)
    );

`ifdef BRINGUP_REPORTER_HEARTBEAT_EN
    logic hb_tick;
    logic hb_clr;

    bringup_tick #(.PERIOD(HEARTBEAT_PERIOD)) u_hb (
        .clock   (clock),
        .reset_n (reset_n),
        .tick_o  (hb_tick)
    );

    // A single pending heartbeat; expiry while pending is not queued.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hb_pend <= 1'b0;
        end else if (hb_clr) begin
            hb_pend <= 1'b0;
        end else if (hb_tick) begin
            hb_pend <= 1'b1;
        end
    end
`else
    assign hb_pend = 1'b0;
`endif

    // Widen the sensor vector so any 7-bit index selects in range.
    always_comb begin
        sensed_ext                  = '0;
        sensed_ext[NUM_SENSORS-1:0] = sensed_i;
    end

    assign cur      = sensed_ext[idx_q];
    assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    // Scan/emit control: compare one sensor per cycle, hold until accept.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        rep_d   = rep_q;
`ifdef BRINGUP_REPORTER_HEARTBEAT_EN
        hb_clr  = 1'b0;
`endif
        unique case (state_q)
            SCAN: begin
                if (hb_pend) begin
                    data_d  = HEARTBEAT_BYTE;
                    state_d = EMIT;
`ifdef BRINGUP_REPORTER_HEARTBEAT_EN
                    hb_clr  = 1'b1;
`endif
                end else if (cur != rep_q[idx_q]) begin
                    data_d       = event_byte(cur, idx_q);
                    rep_d[idx_q] = cur;
                    state_d      = EMIT;
                end else begin
                    idx_d = idx_next;
                end
            end
            EMIT: begin
                if (evt.ready_i) begin
                    state_d = SCAN;
`ifdef BRINGUP_REPORTER_HEARTBEAT_EN
                    idx_d   = (data_q == HEARTBEAT_BYTE) ? idx_q : idx_next;
`else
                    idx_d   = idx_next;
`endif
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // State, index, event byte and reported-value registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SCAN;
            idx_q   <= '0;
            data_q  <= 8'h00;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            rep_q   <= rep_d;
        end
    end

    assign evt.data_o  = data_q;
    assign evt.valid_o = (state_q == EMIT);
    assign busy_o      = (state_q == EMIT);

endmodule

// File: tb/tb_bringup_reporter.sv
// Scoreboard bench for bringup_reporter (NUM_SENSORS=8, DEC_PERIOD=8).
// Expected bytes come from a host-side view of reported values.
module tb_bringup_reporter;

    localparam int N  = 8;
    localparam int DP = 8;
    localparam int HP = 64;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] sensed  = '0;
    logic         dec_o;
    logic         busy_o;

    bringup_reporter_if evt ();

    bringup_reporter #(
        .NUM_SENSORS      (N),
        .DEC_PERIOD       (DP),
        .HEARTBEAT_PERIOD (HP)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .sensed_i (sensed),
        .dec_o    (dec_o),
        .busy_o   (busy_o),
        .evt      (evt)
    );

    always #5 clock = ~clock;

    int           checks = 0;
    int           errors = 0;
    int           accepts = 0;
    int           hb_seen = 0;
    int           ptr;
    bit           rnd_en = 1'b0;
    logic [7:0]   expq[$];
    logic [N-1:0] host_rep = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Where the scanner will look next: one slot per idle cycle,
    // resuming just past the index of each accepted byte.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 0;
        end else if (evt.valid_o && evt.ready_i) begin
            if (evt.data_o == 8'hFF) begin
                ptr <= (ptr + N - 1) % N;
            end else begin
                ptr <= (int'(evt.data_o[6:0]) + 1) % N;
            end
        end else if (!evt.valid_o) begin
            ptr <= (ptr + 1) % N;
        end
    end

    // Monitor: pop and compare on each accept; check hold during stalls.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(evt.valid_o), 32'd1);
                check("hold_data", 32'(evt.data_o), 32'(prev_data));
            end
            if (evt.valid_o && evt.ready_i) begin
                accepts++;
`ifdef BRINGUP_REPORTER_HEARTBEAT_EN
                if (evt.data_o == 8'hFF) begin
                    hb_seen++;
                end else
`endif
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got %0h expected none",
                             evt.data_o);
                end else begin
                    check("event_byte", 32'(evt.data_o),
                          32'(expq.pop_front()));
                end
            end
            prev_stall = evt.valid_o && !evt.ready_i;
            prev_data  = evt.data_o;
        end
    end

    // Decay pulse: high exactly when cycles since release % DP == DP-1.
    int dc = 0;
    always @(negedge clock) begin
        if (!reset_n) begin
            dc = 0;
        end else begin
            check("dec_o", 32'(dec_o), 32'((dc % DP) == DP - 1));
            dc++;
        end
    end

    // Random backpressure.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (rnd_en) evt.ready_i = 1'($urandom_range(0, 1));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Every sensor whose new value differs from what the host holds
    // yields one byte, ascending from the scan position with wrap.
    task automatic apply(input logic [N-1:0] nv);
        for (int k = 0; k < N; k++) begin
            int i = (ptr + k) % N;
            if (nv[i] !== host_rep[i]) begin
                expq.push_back({nv[i], 7'(i)});
                host_rep[i] = nv[i];
            end
        end
        sensed = nv;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((expq.size() != 0 || evt.valid_o) && n < budget) begin
            step(1);
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_valid(input string name, input int budget,
                              output int n);
        n = 0;
        while (!evt.valid_o && n < budget) begin
            step(1);
            n++;
        end
        check(name, 32'(evt.valid_o), 32'd1);
    endtask

    initial begin
        int n;
        int a0;
        evt.ready_i = 1'b0;
        step(3);
        check("rst_valid", 32'(evt.valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_dec", 32'(dec_o), 32'd0);
        check("rst_data", 32'(evt.data_o), 32'd0);
        reset_n = 1'b1;
        evt.ready_i = 1'b1;

        step(30);
        check("idle_no_event", 32'(accepts - hb_seen), 32'd0);

        apply(sensed | 8'h20);
        wait_valid("lat_85_valid", 20, n);
        check("lat_85_bound", 32'(n <= N + 1), 32'd1);
        wait_drain("drain_85", 40);
        apply(sensed & ~8'h20);
        wait_drain("drain_05", 40);

        n = 0;
        while (ptr != 0 && n < 2 * N) begin
            step(1);
            n++;
        end
        check("ptr_zero", 32'(ptr), 32'd0);
        apply(sensed | 8'h44);
        wait_drain("drain_82_86", 60);

        apply(8'h00);
        wait_drain("drain_clear", 60);
        evt.ready_i = 1'b0;
        apply(8'h80);
        wait_valid("stall_valid", 20, n);
        a0 = accepts;
        for (int c = 0; c < 50; c++) begin
            if (c == 10) apply(sensed | 8'h08);
            step(1);
        end
        check("stall_no_accept", 32'(accepts - a0), 32'd0);
        check("stall_data", 32'(evt.data_o), 32'h87);
        evt.ready_i = 1'b1;
        wait_drain("drain_stall", 60);
        check("stall_accepts", 32'(accepts - a0 - hb_seen), 32'd2);

        apply(8'h00);
        wait_drain("drain_clear2", 60);
        evt.ready_i = 1'b0;
        apply(8'h02);
        wait_valid("pre_rst_valid", 20, n);
        step(3);
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(evt.valid_o), 32'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        expq.delete();
        host_rep = '0;
        step(2);
        reset_n = 1'b1;
        evt.ready_i = 1'b1;
        apply(sensed);
        check("re_report_queued", 32'(expq[0]), 32'h81);
        wait_drain("drain_81", 40);

        rnd_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            apply(N'($urandom));
            wait_drain("drain_rand", 600);
            step(int'($urandom_range(0, 5)));
        end
        rnd_en = 1'b0;
        step(1);
        evt.ready_i = 1'b1;

        a0 = accepts;
        step(200);
`ifdef BRINGUP_REPORTER_HEARTBEAT_EN
        check("hb_bytes", 32'(accepts - a0 >= 3), 32'd1);
`else
        check("no_heartbeat", 32'(accepts - a0), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bringup_reporter.md
Name: bringup_reporter

Overview:
- Downstream consumer of a bank of bringup sensors.
- Generates the shared periodic decay pulse that feeds every sensor's dec_i.
- Scans the sensors' sensed outputs and reports each change as a one-byte event on a valid/ready stream, which typically feeds the UART transmitter.
- The host can therefore map live board pins without polling.

Parameters:
- NUM_SENSORS, 32, number of sensed inputs; legal range 1..127 (index 127 reserved).
- DEC_PERIOD, 1024, clock cycles between dec_o pulses; legal minimum 2.
- HEARTBEAT_PERIOD, 2^20, cycles between heartbeat bytes (used only with the optional feature).

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset_n  input  1  reset, asynchronous, active-low.
- sensed_i  input  NUM_SENSORS  sensed_o of each sensor, synchronous to clock.
- dec_o  output  1  one-cycle decay pulse, fanned out to every sensor's dec_i.
- data_o  output  8  event byte: bit7 = new sensed value, bits6:0 = sensor index.
- valid_o  output  1  data_o holds an event.
- ready_i  input  1  consumer accepts data_o this cycle.
- busy_o  output  1  high while in EMIT state.

Behaviour:
- Clock and reset: single clock. Reset is asynchronous, active-low. While reset_n=0:
  - valid_o=0, busy_o=0, dec_o=0, data_o=8'h00.
  - Reported-state register cleared to all 0.
  - Scan index = 0, decay counter = 0, state = SCAN.
- Decay tick:
  - Counter runs 0..DEC_PERIOD-1 and wraps.
  - dec_o=1 exactly in the cycle the counter equals DEC_PERIOD-1.
  - The first pulse is in cycle DEC_PERIOD-1 after reset release.
  - Free-running; independent of state and of the handshake.
- Reported state: one bit per sensor holding the last value sent to the host.
- State SCAN:
  - Each cycle, compare sensed_i[idx] with reported[idx].
  - Equal: idx advances; wraps from NUM_SENSORS-1 to 0.
  - Differ:
    - Register data_o = {sensed_i[idx], idx[6:0]}.
    - Set reported[idx] = sensed_i[idx].
    - valid_o=1 on the next cycle; go to EMIT. idx holds.
- State EMIT:
  - data_o and valid_o are held stable until ready_i=1.
  - On valid_o && ready_i: valid_o=0 next cycle, idx advances, return to SCAN.
  - No new comparison happens during EMIT.
  - ready_i without valid_o has no effect.
- Latency:
  - Change to valid_o within NUM_SENSORS+1 cycles when the stream is unstalled.
  - Each stalled EMIT adds its own duration.
- Simultaneous and ordering rules:
  - Several changes are reported one byte each, in ascending index order starting from the current idx.
  - A sensor that toggles twice before its scan slot produces no event.
  - A change during EMIT is picked up on a later pass.
  - No events are lost. Only the final value at scan time matters.
- Back-to-back throughput: one event per 2 cycles minimum (SCAN compare, EMIT accept).
- Reset mid-EMIT: the pending byte is dropped and valid_o falls immediately (asynchronously). After release, any sensed_i=1 is re-reported as a change.

Optional Feature:
- Macro: BRINGUP_REPORTER_HEARTBEAT_EN.
- With the macro defined:
  - A counter raises a pending flag every HEARTBEAT_PERIOD cycles.
  - In SCAN, a pending heartbeat takes priority over the compare: emit data_o=8'hFF, clear the flag, go to EMIT. idx does not advance, so the same idx is compared after the accept.
  - Expiry while the flag is already set does not queue a second heartbeat.
- Without the macro: no heartbeat counter or logic is present, and 8'hFF is never emitted.

Decomposition:
- Package bringup_pkg holds:
  - IDX_BITS=7;
  - HEARTBEAT_BYTE=8'hFF;
  - MAX_SENSORS=127;
  - the state enum {SCAN, EMIT};
  - the event byte field positions (VALUE_BIT=7, IDX_MSB=6).
- Sub-module bringup_tick is natural: parameter PERIOD, ports clock, reset_n, tick_o. It is instantiated for the decay pulse, and with the feature defined also for the heartbeat.

Test Plan:
- Reset release with DEC_PERIOD=8 -> dec_o high in cycles 7, 15, 23; valid_o stays 0 with sensed_i all 0.
- NUM_SENSORS=8, ready_i=1, sensed_i[5] rises -> one byte 8'h85 with valid_o for one cycle within 9 cycles; sensed_i[5] falls -> 8'h05.
- sensed_i[2] and sensed_i[6] rise in the same cycle, idx=0 -> 8'h82 then 8'h86, never reordered.
- ready_i held 0 for 50 cycles while an event is pending -> data_o/valid_o stable for 50 cycles; exactly one accept; sensed_i[3] rising during the stall produces 8'h83 after it.
- reset_n asserted mid-EMIT with sensed_i[1]=1 -> valid_o drops the same cycle; after release, 8'h81 is re-emitted.
- With BRINGUP_REPORTER_HEARTBEAT_EN and HEARTBEAT_PERIOD=64, idle sensors -> 8'hFF every 64 cycles. With the macro undefined -> no byte ever.
